// File: rtl/pll_drp_seq.sv
// Reprograms a PLL feedback multiplier over DRP: hold PLL in reset, read-modify-write
// both feedback registers, release and wait for lock. Also drives the downstream reset.
`timescale 1ns/1ps
module pll_drp_seq #(
  parameter logic [6:0] ADDR1   = 7'h14,
  parameter logic [6:0] ADDR2   = 7'h15,
  parameter int         LBW     = 16,
  parameter int         DRDY_TO = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req_i,
  input  logic [5:0]     mult_i,
  input  logic [LBW-1:0] lock_timeout_i,
  input  logic           locked_i,
  input  logic [15:0]    drp_do_i,
  input  logic           drdy_i,
  output logic [6:0]     daddr_o,
  output logic [15:0]    drp_di_o,
  output logic           den_o,
  output logic           dwe_o,
  output logic           pll_rst_o,
  output logic           busy_o,
  output logic           done_o,
  output logic           err_o,
  output logic           rstxo_o
);

  localparam int TOW = (DRDY_TO < 4) ? 2 : $clog2(DRDY_TO);
  localparam logic [TOW-1:0] TO_LAST = TOW'(DRDY_TO - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST, S_RD1, S_RD1W, S_WR1, S_WR1W,
    S_RD2, S_RD2W, S_WR2, S_WR2W, S_REL, S_LOCKW
  } state_t;

  state_t           state_q, state_d;
  logic             req_q;
  logic [5:0]       mult_q;
  logic [5:0]       m_q, m_d;
  logic             sync1_q, lk_s_q;
  logic [TOW-1:0]   to_cnt_q, to_cnt_d;
  logic [LBW-1:0]   lock_cnt_q, lock_cnt_d;
  logic [6:0]       daddr_q, daddr_d;
  logic [15:0]      drp_di_q, drp_di_d;
  logic             den_q, den_d, dwe_q, dwe_d;
  logic             pll_rst_q, pll_rst_d, busy_q, busy_d;
  logic             done_q, done_d, err_q, err_d, rstxo_q;
  logic             abort;
  logic [5:0]       hi, lo;
  logic [15:0]      reg1_new, reg2_new;
  logic             unused_drp_bits;

  assign hi       = m_q >> 1;
  assign lo       = m_q - hi;
  assign reg1_new = {drp_do_i[15:12], hi, lo};
  assign reg2_new = {drp_do_i[15:8], 1'b0, m_q[0], drp_do_i[5:0]};
  assign unused_drp_bits = ^drp_do_i[7:6];

  // Outputs are registered on entry to each state, so next-state and next-output go together.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    to_cnt_d   = '0;
    lock_cnt_d = lock_cnt_q;
    daddr_d    = daddr_q;
    drp_di_d   = drp_di_q;
    den_d      = 1'b0;
    dwe_d      = 1'b0;
    pll_rst_d  = pll_rst_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    abort      = 1'b0;
    case (state_q)
      S_IDLE: if (req_q) begin
        if (mult_q >= 6'd2) begin
          m_d       = mult_q;
          busy_d    = 1'b1;
          pll_rst_d = 1'b1;
          state_d   = S_RST;
        end else begin
          err_d = 1'b1;
        end
      end
      S_RST: begin
        den_d   = 1'b1;
        daddr_d = ADDR1;
        state_d = S_RD1;
      end
      S_RD1: state_d = S_RD1W;
      S_RD1W: if (drdy_i) begin
        den_d    = 1'b1;
        dwe_d    = 1'b1;
        drp_di_d = reg1_new;
        state_d  = S_WR1;
      end else if (to_cnt_q == TO_LAST) abort = 1'b1;
      else to_cnt_d = to_cnt_q + 1'b1;
      S_WR1: state_d = S_WR1W;
      S_WR1W: if (drdy_i) begin
        den_d   = 1'b1;
        daddr_d = ADDR2;
        state_d = S_RD2;
      end else if (to_cnt_q == TO_LAST) abort = 1'b1;
      else to_cnt_d = to_cnt_q + 1'b1;
      S_RD2: state_d = S_RD2W;
      S_RD2W: if (drdy_i) begin
        den_d    = 1'b1;
        dwe_d    = 1'b1;
        drp_di_d = reg2_new;
        state_d  = S_WR2;
      end else if (to_cnt_q == TO_LAST) abort = 1'b1;
      else to_cnt_d = to_cnt_q + 1'b1;
      S_WR2: state_d = S_WR2W;
      S_WR2W: if (drdy_i) begin
        pll_rst_d = 1'b0;
        state_d   = S_REL;
      end else if (to_cnt_q == TO_LAST) abort = 1'b1;
      else to_cnt_d = to_cnt_q + 1'b1;
      S_REL: begin
        lock_cnt_d = '0;
        state_d    = S_LOCKW;
      end
      S_LOCKW: if (lk_s_q) begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else if (lock_cnt_q == lock_timeout_i) begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end else if (lock_cnt_q != '1) begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // A missing DRDY leaves any already-written register untouched.
    if (abort) begin
      err_d     = 1'b1;
      pll_rst_d = 1'b0;
      busy_d    = 1'b0;
      state_d   = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      req_q      <= 1'b0;
      mult_q     <= '0;
      m_q        <= '0;
      sync1_q    <= 1'b0;
      lk_s_q     <= 1'b0;
      to_cnt_q   <= '0;
      lock_cnt_q <= '0;
      daddr_q    <= '0;
      drp_di_q   <= '0;
      den_q      <= 1'b0;
      dwe_q      <= 1'b0;
      pll_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rstxo_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_i;
      mult_q     <= mult_i;
      m_q        <= m_d;
      sync1_q    <= locked_i;
      lk_s_q     <= sync1_q;
      to_cnt_q   <= to_cnt_d;
      lock_cnt_q <= lock_cnt_d;
      daddr_q    <= daddr_d;
      drp_di_q   <= drp_di_d;
      den_q      <= den_d;
      dwe_q      <= dwe_d;
      pll_rst_q  <= pll_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rstxo_q    <= ~busy_q & lk_s_q;
    end
  end

  assign daddr_o   = daddr_q;
  assign drp_di_o  = drp_di_q;
  assign den_o     = den_q;
  assign dwe_o     = dwe_q;
  assign pll_rst_o = pll_rst_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign rstxo_o   = rstxo_q;

endmodule

// File: tb/tb_pll_drp_seq.sv
// Directed bench for pll_drp_seq: a DRP responder with 1-cycle DRDY and a write log.
`timescale 1ns/1ps
module tb_pll_drp_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0;
  logic [5:0]  mult_i = '0;
  logic [15:0] lock_timeout_i = 16'd1000;
  logic        locked_i = 1'b0;
  logic [15:0] drp_do_i = '0;
  logic        drdy_i = 1'b0;
  logic [6:0]  daddr_o;
  logic [15:0] drp_di_o;
  logic        den_o, dwe_o, pll_rst_o, busy_o, done_o, err_o, rstxo_o;

  int compared = 0;
  int mismatched = 0;

  logic [15:0] rdData1 = '0, rdData2 = '0;
  logic        muteEn = 1'b0, muteWrite = 1'b0;
  logic [6:0]  muteAddr = '0;
  logic        pending = 1'b0, prevDen = 1'b0;
  logic [6:0]  pendAddr = '0;
  int          denCount = 0, denAdjacent = 0, wrCount = 0, bothCount = 0;
  logic [6:0]  wrAddr [8];
  logic [15:0] wrData [8];

  pll_drp_seq dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .mult_i(mult_i),
    .lock_timeout_i(lock_timeout_i), .locked_i(locked_i),
    .drp_do_i(drp_do_i), .drdy_i(drdy_i), .daddr_o(daddr_o),
    .drp_di_o(drp_di_o), .den_o(den_o), .dwe_o(dwe_o), .pll_rst_o(pll_rst_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .rstxo_o(rstxo_o)
  );

  always #5 clk = ~clk;

  // DRP slave: DRDY is returned in the cycle after each DEN unless that access is muted.
  always @(negedge clk) begin
    drdy_i = 1'b0;
    if (pending) begin
      drdy_i   = 1'b1;
      drp_do_i = (pendAddr == 7'h14) ? rdData1 : rdData2;
    end
    pending = 1'b0;
    if (den_o) begin
      denCount++;
      if (prevDen) denAdjacent++;
      if (!(muteEn && daddr_o == muteAddr && dwe_o == muteWrite)) begin
        pending  = 1'b1;
        pendAddr = daddr_o;
      end
      if (dwe_o && wrCount < 8) begin
        wrAddr[wrCount] = daddr_o;
        wrData[wrCount] = drp_di_o;
        wrCount++;
      end
    end
    prevDen = den_o;
    if (done_o && err_o) bothCount++;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearLog();
    wrCount = 0;
    denCount = 0;
    denAdjacent = 0;
  endtask

  task automatic doReq(input logic [5:0] m);
    @(negedge clk);
    req_i  = 1'b1;
    mult_i = m;
    @(negedge clk);
    req_i  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    compared++;
    if ({daddr_o, drp_di_o, den_o, dwe_o, pll_rst_o, busy_o, done_o, err_o, rstxo_o} !== 30'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h expected 0",
               {daddr_o, drp_di_o, den_o, dwe_o, pll_rst_o, busy_o, done_o, err_o, rstxo_o});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if (rstxo_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rstxo_unlocked: got %b expected 0", rstxo_o);
    end
    locked_i = 1'b1;
    repeat (4) @(negedge clk);
    compared++;
    if (rstxo_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rstxo_idle_locked: got %b expected 1", rstxo_o);
    end
  endtask

  task automatic test_nominal();
    int k;
    int n;
    clearLog();
    rdData1 = 16'hF000;
    rdData2 = 16'hFF3F;
    locked_i = 1'b0;
    doReq(6'd10);
    compared++;
    if (busy_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL busy_at_edge0: got %b expected 0", busy_o);
    end
    @(negedge clk);
    compared++;
    if ({busy_o, pll_rst_o} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL busy_rst_edge1: got %b expected 11", {busy_o, pll_rst_o});
    end
    @(negedge clk);
    compared++;
    if ({den_o, dwe_o, daddr_o, rstxo_o} !== {1'b1, 1'b0, 7'h14, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL first_read_edge2: got %h expected %h",
               {den_o, dwe_o, daddr_o, rstxo_o}, {1'b1, 1'b0, 7'h14, 1'b0});
    end
    for (k = 3; k < 40; k++) begin
      @(negedge clk);
      if (!pll_rst_o) break;
    end
    compared++;
    if (k !== 10) begin
      mismatched++;
      $display("[TB] FAIL nominal_rst_fall: got %0d expected 10", k);
    end
    compared++;
    if ({wrCount[3:0], wrAddr[0], wrData[0], wrAddr[1], wrData[1]} !==
        {4'd2, 7'h14, 16'hF145, 7'h15, 16'hFF3F}) begin
      mismatched++;
      $display("[TB] FAIL nominal_writes: got n=%0d %h:%h %h:%h expected n=2 14:f145 15:ff3f",
               wrCount, wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
    end
    compared++;
    if (denCount !== 4 || denAdjacent !== 0) begin
      mismatched++;
      $display("[TB] FAIL den_pulses: got count=%0d adjacent=%0d expected 4/0", denCount, denAdjacent);
    end
    repeat (20) @(negedge clk);
    locked_i = 1'b1;
    for (n = 1; n < 10; n++) begin
      @(negedge clk);
      if (done_o) break;
    end
    compared++;
    if (n !== 3) begin
      mismatched++;
      $display("[TB] FAIL done_latency: got %0d expected 3", n);
    end
    compared++;
    if ({busy_o, err_o, rstxo_o} !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL done_cycle_flags: got %b expected 000", {busy_o, err_o, rstxo_o});
    end
    @(negedge clk);
    compared++;
    if ({done_o, rstxo_o} !== 2'b01) begin
      mismatched++;
      $display("[TB] FAIL rstxo_after_done: got %b expected 01", {done_o, rstxo_o});
    end
  endtask

  task automatic test_odd();
    int k;
    int n;
    clearLog();
    rdData1 = 16'h0000;
    rdData2 = 16'h0000;
    locked_i = 1'b0;
    doReq(6'd7);
    for (k = 1; k < 40; k++) begin
      @(negedge clk);
      if (!pll_rst_o) break;
    end
    compared++;
    if ({wrCount[3:0], wrAddr[0], wrData[0], wrAddr[1], wrData[1]} !==
        {4'd2, 7'h14, 16'h00C4, 7'h15, 16'h0040}) begin
      mismatched++;
      $display("[TB] FAIL odd_writes: got n=%0d %h:%h %h:%h expected n=2 14:00c4 15:0040",
               wrCount, wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
    end
    locked_i = 1'b1;
    for (n = 1; n < 10; n++) begin
      @(negedge clk);
      if (done_o) break;
    end
    compared++;
    if (n !== 3) begin
      mismatched++;
      $display("[TB] FAIL odd_done: got %0d expected 3", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reject();
    int errs;
    int busySeen;
    int rstSeen;
    int k;
    int n;
    clearLog();
    errs = 0; busySeen = 0; rstSeen = 0;
    doReq(6'd1);
    repeat (6) begin
      @(negedge clk);
      if (err_o) errs++;
      if (busy_o) busySeen++;
      if (pll_rst_o) rstSeen++;
    end
    compared++;
    if (errs !== 1 || busySeen !== 0 || rstSeen !== 0 || denCount !== 0) begin
      mismatched++;
      $display("[TB] FAIL reject_mult1: got err=%0d busy=%0d rst=%0d den=%0d expected 1/0/0/0",
               errs, busySeen, rstSeen, denCount);
    end
    clearLog();
    errs = 0;
    rdData1 = 16'hF000;
    rdData2 = 16'hFF3F;
    locked_i = 1'b0;
    doReq(6'd10);
    @(negedge clk);
    doReq(6'd1);
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (err_o) errs++;
      if (!pll_rst_o) break;
    end
    compared++;
    if (errs !== 0 || wrCount !== 2 || wrData[0] !== 16'hF145) begin
      mismatched++;
      $display("[TB] FAIL req_while_busy: got err=%0d n=%0d w0=%h expected 0/2/f145",
               errs, wrCount, wrData[0]);
    end
    locked_i = 1'b1;
    for (n = 1; n < 10; n++) begin
      @(negedge clk);
      if (done_o) break;
    end
    compared++;
    if (n !== 3) begin
      mismatched++;
      $display("[TB] FAIL busy_seq_done: got %0d expected 3", n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_drdy_timeout();
    int k;
    clearLog();
    muteEn = 1'b1; muteAddr = 7'h15; muteWrite = 1'b0;
    locked_i = 1'b0;
    doReq(6'd10);
    for (k = 1; k < 400; k++) begin
      @(negedge clk);
      if (err_o) break;
    end
    compared++;
    if (k !== 262) begin
      mismatched++;
      $display("[TB] FAIL drdy_timeout_cycle: got %0d expected 262", k);
    end
    compared++;
    if ({pll_rst_o, busy_o, done_o} !== 3'b000 || wrCount !== 1) begin
      mismatched++;
      $display("[TB] FAIL drdy_timeout_state: got %b n=%0d expected 000 n=1",
               {pll_rst_o, busy_o, done_o}, wrCount);
    end
    @(negedge clk);
    compared++;
    if (err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL drdy_err_pulse: got %b expected 0", err_o);
    end
    muteEn = 1'b0;
  endtask

  task automatic test_lock_timeout();
    int k;
    clearLog();
    lock_timeout_i = 16'd100;
    locked_i = 1'b0;
    doReq(6'd10);
    for (k = 1; k < 300; k++) begin
      @(negedge clk);
      if (err_o) break;
    end
    compared++;
    if (k !== 112) begin
      mismatched++;
      $display("[TB] FAIL lock_timeout_cycle: got %0d expected 112", k);
    end
    compared++;
    if ({pll_rst_o, busy_o, rstxo_o, done_o} !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL lock_timeout_state: got %b expected 0000", {pll_rst_o, busy_o, rstxo_o, done_o});
    end
    repeat (3) @(negedge clk);
    compared++;
    if (rstxo_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL lock_timeout_rstxo: got %b expected 0", rstxo_o);
    end
    lock_timeout_i = 16'd1000;
  endtask

  task automatic test_reset_mid();
    int k;
    int n;
    clearLog();
    muteEn = 1'b1; muteAddr = 7'h14; muteWrite = 1'b1;
    rdData1 = 16'hF000;
    rdData2 = 16'hFF3F;
    locked_i = 1'b0;
    doReq(6'd10);
    repeat (7) @(negedge clk);
    compared++;
    if ({busy_o, pll_rst_o} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL mid_before_reset: got %b expected 11", {busy_o, pll_rst_o});
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if ({daddr_o, drp_di_o, den_o, dwe_o, pll_rst_o, busy_o, done_o, err_o, rstxo_o} !== 30'd0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_outputs: got %h expected 0",
               {daddr_o, drp_di_o, den_o, dwe_o, pll_rst_o, busy_o, done_o, err_o, rstxo_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    muteEn = 1'b0;
    clearLog();
    doReq(6'd12);
    for (k = 1; k < 40; k++) begin
      @(negedge clk);
      if (!pll_rst_o) break;
    end
    compared++;
    if (k !== 10 || {wrCount[3:0], wrAddr[0], wrData[0], wrAddr[1], wrData[1]} !==
        {4'd2, 7'h14, 16'hF186, 7'h15, 16'hFF3F}) begin
      mismatched++;
      $display("[TB] FAIL after_reset_writes: got k=%0d n=%0d %h:%h %h:%h expected k=10 n=2 14:f186 15:ff3f",
               k, wrCount, wrAddr[0], wrData[0], wrAddr[1], wrData[1]);
    end
    locked_i = 1'b1;
    for (n = 1; n < 10; n++) begin
      @(negedge clk);
      if (done_o) break;
    end
    @(negedge clk);
    compared++;
    if (n !== 3 || rstxo_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL after_reset_done: got n=%0d rstxo=%b expected 3/1", n, rstxo_o);
    end
  endtask

  task automatic test_no_overlap();
    compared++;
    if (bothCount !== 0) begin
      mismatched++;
      $display("[TB] FAIL done_err_overlap: got %0d expected 0", bothCount);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_odd();
    test_reject();
    test_drdy_timeout();
    test_lock_timeout();
    test_reset_mid();
    test_no_overlap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pll_drp_seq.md
# pll_drp_seq

Sequencer that reprograms the feedback multiplier of a PLL through its dynamic reconfiguration port (DRP) when a new multiplier value is requested. It holds the PLL in reset, read-modify-writes the two feedback-divider registers, releases the reset and waits for lock. It also generates the downstream reset `RSTXO`. It sits between the button/display control logic, which issues `REQ`/`MULT`, and the PLL primitive.

## Interface
- `ADDR1`, 7'h14: DRP address of feedback register 1.
- `ADDR2`, 7'h15: DRP address of feedback register 2.
- `LBW`, 16: width of the lock-timeout counter.
- `DRDY_TO`, 255: maximum cycles to wait for `DRDY` after a `DEN` pulse.
- `RSTX  in  1`: reset, asynchronous, active-low. One clock `CLK`; reset is asynchronous and active-low.
- `CLK  in  1`: clock.
- `REQ  in  1`: one-cycle request to apply `MULT`.
- `MULT  in  6`: new feedback multiplier; valid range 2..63.
- `LOCK_TIMEOUT  in  LBW`: maximum cycles to wait for lock after release.
- `LOCKED  in  1`: PLL lock, asynchronous to `CLK`.
- `DRP_DO  in  16`: DRP read data.
- `DRDY  in  1`: DRP ready.
- `DADDR  out  7`: DRP address.
- `DRP_DI  out  16`: DRP write data.
- `DEN  out  1`: DRP enable, one-cycle pulse.
- `DWE  out  1`: DRP write enable, valid only with `DEN`.
- `PLL_RST  out  1`: PLL reset, active-high.
- `BUSY  out  1`: high from request acceptance until `DONE` or `ERR`.
- `DONE  out  1`: one-cycle pulse on successful completion.
- `ERR  out  1`: one-cycle pulse on rejected request or timeout.
- `RSTXO  out  1`: active-low reset for downstream logic.

## Operation
- **Lock synchronisation:** `LOCKED` passes through a 2-flop synchroniser to give `lk_s`.
- **`RSTXO` rule:**
  - `RSTXO` = ~`BUSY` & `lk_s`, registered.
  - Reset value 0.
- **Field computation** from the captured `M`:
  - hi = M>>1; lo = M−hi; edge = M[0].
  - Register 1 new value = {rd[15:12], hi[5:0], lo[5:0]}.
  - Register 2 new value = {rd[15:8], 1'b0, edge, rd[5:0]}, i.e. bit 7 (no-count) = 0 and bit 6 = edge.
- **State machine:**
  - **IDLE:**
    - On `REQ` with 2 ≤ `MULT` ≤ 63: capture `MULT`, set `BUSY`, go to RST.
    - On `REQ` with `MULT` < 2: pulse `ERR` and stay in IDLE; `BUSY` stays low.
  - **RST:** `PLL_RST`=1 (registered, stays high through WR2W), go to RD1.
  - **RD1:** `DEN`=1, `DWE`=0, `DADDR`=`ADDR1`; go to RD1W.
  - **RD1W:** wait for `DRDY`, latch `DRP_DO`, go to WR1.
  - **WR1:** `DEN`=1, `DWE`=1, `DRP_DI`=register 1 new value; go to WR1W.
  - **WR1W:** wait for `DRDY`, go to RD2.
  - **RD2 / RD2W / WR2 / WR2W:** same sequence as RD1..WR1W, using `ADDR2` and register 2 new value.
  - **REL:** `PLL_RST`=0, clear the lock counter, go to LOCKW.
  - **LOCKW:**
    - When `lk_s`=1: pulse `DONE`, clear `BUSY`, go to IDLE.
    - When the counter reaches `LOCK_TIMEOUT`: pulse `ERR`, clear `BUSY`, go to IDLE. `PLL_RST` stays 0.
- **DRDY timeout:**
  - In any *W state, `DRDY` absent for `DRDY_TO` cycles → pulse `ERR`, drive `PLL_RST`=0, clear `BUSY`, go to IDLE.
  - The written registers are left as-is.
- **Request filtering:**
  - `REQ` while `BUSY` is ignored (no `ERR`, no queueing).
  - `DRDY` outside a *W state is ignored.
- **Reset values** (all outputs):
  - `DADDR`=0, `DRP_DI`=0, `DEN`=0, `DWE`=0, `PLL_RST`=0.
  - `BUSY`=0, `DONE`=0, `ERR`=0, `RSTXO`=0.
  - State = IDLE; synchroniser flops = 0.
- **Reset mid-sequence:** the FSM returns to IDLE and `PLL_RST` drops to 0 asynchronously. Any partial DRP write is not rolled back.

## Timing
- `REQ` sampled at edge 0:
  - `BUSY`=1 and `PLL_RST`=1 after edge 1 (state RST); `RSTXO`=0 after edge 2.
  - First `DEN` (read of `ADDR1`) after edge 2.
- Each DRP access:
  - `DEN` is high for exactly one cycle.
  - The next access's `DEN` is asserted no earlier than 1 cycle after the `DRDY` cycle.
  - Read data is sampled in the `DRDY` cycle.
- With 1-cycle `DRDY` response: `PLL_RST` falls 10 cycles after `REQ`.
- `DONE` follows `lk_s` by 1 cycle, i.e. 3 cycles after `LOCKED` rises, or less if `LOCKED` is already high. `RSTXO` rises 1 cycle after `DONE`.
- The lock counter is `LBW` bits and saturates. `LOCK_TIMEOUT`=0 means timeout on the first LOCKW cycle unless `lk_s`=1.
- `DONE` and `ERR` are never high in the same cycle.

## Test plan
- **Nominal:** `MULT`=10, `DRP_DO` returns 16'hF000 / 16'hFF3F, `DRDY` 1 cycle after each `DEN`.
  - Writes 16'hF145 to `ADDR1` and 16'hFF3F→16'hFF00|edge... expected 16'hFF3F with bits[7:6]=00, i.e. 16'hFF3F.
  - `LOCKED` rises 20 cycles after `PLL_RST` falls → `DONE` pulse, `RSTXO` returns to 1.
- **Odd multiplier:** `MULT`=7, register reads 16'h0000/16'h0000.
  - Writes 16'h00C4 (hi=3, lo=4) and 16'h0040 (edge=1).
- **Reject:** `MULT`=1 with `REQ` → `ERR` pulse, no `DEN`, `BUSY` and `PLL_RST` stay 0. A second `REQ` during `BUSY` is ignored.
- **Timeouts:**
  - `DRDY` never returned on RD2 → `ERR` after `DRDY_TO`=255 cycles, `PLL_RST`=0.
  - `LOCK_TIMEOUT`=100 with `LOCKED` held low → `ERR` after 100 cycles, `RSTXO` stays 0.
- **Reset mid-operation:** `RSTX` pulsed low during WR1W → all outputs at reset values immediately. A following `REQ` with `MULT`=12 completes normally.
